// File: rtl/seq_alu_unit_if.sv
// Request/response bus of the sequential ALU.
// The command source uses the master modport and the ALU uses the slave modport.
interface seq_alu_unit_if #(
    parameter int DATA_W = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            op_code;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DATA_W-1:0]   result;
    logic                  err;

    modport master (
        output req_valid, op_code, a, b, rsp_ready,
        input  req_ready, rsp_valid, result, err
    );

    modport slave (
        input  req_valid, op_code, a, b, rsp_ready,
        output req_ready, rsp_valid, result, err
    );
endinterface

// File: rtl/seq_alu_unit.sv
// Multi-cycle unsigned ALU with a valid/ready request and response channel.
// Add, sub and divide-by-zero finish in the accept cycle. Mul uses LSB-first
// shift-add and div uses MSB-first restoring division. Both take one step per
// cycle for DATA_W cycles.
module seq_alu_unit #(
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_alu_unit_if.slave  bus
);
    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    state_t              state_q;
    state_t              state_d;
    op_t                 op_q;
    op_t                 op_in;
    logic [RES_W-1:0]    acc_q;      // mul: partial product; div: {remainder, quotient}
    logic [RES_W-1:0]    acc_d;
    logic [RES_W-1:0]    mcand_q;    // mul: multiplicand, shifted left each step
    logic [DATA_W-1:0]   opnd_q;     // mul: multiplier, shifted right; div: divisor
    logic [CNT_W-1:0]    cnt_q;
    logic [RES_W-1:0]    result_q;
    logic                err_q;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     trial;
    logic                accept;
    logic                rsp_fire;
    logic                last_step;
    logic                short_op;

    assign op_in     = op_t'(bus.op_code);
    assign accept    = bus.req_valid && bus.req_ready;
    assign rsp_fire  = bus.rsp_valid && bus.rsp_ready;
    assign last_step = (cnt_q == CNT_W'(DATA_W - 1));
    // Add, sub and divide-by-zero need no iteration and go directly to DONE.
    assign short_op  = (op_in == OP_ADD) || (op_in == OP_SUB) ||
                       ((op_in == OP_DIV) && (bus.b == '0));

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.err       = err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Unused encodings recover to IDLE.
    always_comb begin
        // NOTE: the default is assigned before the case, so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = short_op ? DONE : CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    if (rsp_fire)  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // One mul or div iteration, computed from the current accumulator.
    always_comb begin
        acc_d     = acc_q;
        rem_shift = acc_q[RES_W-1:DATA_W-1];
        trial     = rem_shift - {1'b0, opnd_q};
        if (op_q == OP_MUL) begin
            if (opnd_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
        end else if (!trial[DATA_W]) begin
            acc_d = {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
            acc_d = {acc_q[RES_W-2:0], 1'b0};
        end
    end

    // Datapath: latch operands on accept, iterate in CALC, clear err on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are a few discrete registers and not a RAM, so all of them are reset.
        if (!rst_n) begin
            op_q     <= OP_ADD;
            acc_q    <= '0;
            mcand_q  <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            op_q    <= op_in;
            opnd_q  <= bus.b;
            mcand_q <= RES_W'(bus.a);
            cnt_q   <= '0;
            err_q   <= 1'b0;
            case (op_in)
                OP_ADD: result_q <= RES_W'(bus.a) + RES_W'(bus.b);
                OP_SUB: result_q <= RES_W'(bus.a) - RES_W'(bus.b);
                OP_MUL: acc_q    <= '0;
                default: begin
                    if (bus.b == '0) begin
                        result_q <= '1;
                        err_q    <= 1'b1;
                    end else begin
                        acc_q <= RES_W'(bus.a);
                    end
                end
            endcase
        end else if (state_q == CALC) begin
            acc_q   <= acc_d;
            mcand_q <= mcand_q << 1;
            opnd_q  <= (op_q == OP_MUL) ? (opnd_q >> 1) : opnd_q;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_step) begin
                result_q <= acc_d;
            end
        end else if (rsp_fire) begin
            err_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit. It runs directed and random operations
// and compares them against an arithmetic reference model. It also checks
// latency, back-pressure, handshake and mid-operation reset.
module tb_seq_alu_unit;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_alu_unit_if #(.DATA_W(DATA_W)) bus ();

    seq_alu_unit #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns {err, result}.
    function automatic logic [16:0] ref_alu(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        int unsigned xi = x;
        int unsigned yi = y;
        int unsigned r;
        case (op)
            2'd0: r = xi + yi;
            2'd1: r = xi - yi;
            2'd2: r = xi * yi;
            default: begin
                if (yi == 0) return {1'b1, 16'hFFFF};
                r = ((xi % yi) << 8) | (xi / yi);
            end
        endcase
        return {1'b0, r[15:0]};
    endfunction

    // Drives random request-side values. A busy ALU must ignore them.
    task automatic noise();
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.op_code   = 2'($urandom);
        bus.a         = 8'($urandom);
        bus.b         = 8'($urandom);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y, input int bp);
        logic [16:0] exp;
        logic [15:0] held;
        int          exp_lat;
        int          edges;
        exp     = ref_alu(op, x, y);
        exp_lat = (op == 2'd2 || (op == 2'd3 && y != 0)) ? DATA_W + 1 : 1;
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.op_code   = op;
        bus.a         = x;
        bus.b         = y;
        bus.rsp_ready = 1'b0;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            noise();
            if (!bus.rsp_valid) begin
                check("req_ready_busy", 32'(bus.req_ready), 32'd0);
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.rsp_ready = 1'b0;
            end
        end while (!bus.rsp_valid && edges < 40);
        check("latency", 32'(edges), 32'(exp_lat));
        check("result", 32'(bus.result), 32'(exp[15:0]));
        check("err", 32'(bus.err), 32'(exp[16]));
        held = bus.result;
        repeat (bp) begin
            @(posedge clk);
            @(negedge clk);
            noise();
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_result", 32'(bus.result), 32'(held));
            check("bp_err", 32'(bus.err), 32'(exp[16]));
            check("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("hs_valid", 32'(bus.rsp_valid), 32'd0);
        check("hs_err", 32'(bus.err), 32'd0);
        check("hs_ready", 32'(bus.req_ready), 32'd1);
        check("hs_result", 32'(bus.result), 32'(held));
    endtask

    initial begin
        logic       seen;
        logic [1:0] rop;
        logic [7:0] rx;
        logic [7:0] ry;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.op_code   = 2'd0;
        bus.a         = '0;
        bus.b         = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_op(2'd0, 8'd10, 8'd5, 0);
        do_op(2'd1, 8'd20, 8'd8, 0);
        do_op(2'd1, 8'd5, 8'd10, 0);
        do_op(2'd0, 8'd255, 8'd255, 0);
        do_op(2'd2, 8'd12, 8'd10, 0);
        do_op(2'd2, 8'd255, 8'd255, 0);
        do_op(2'd3, 8'd100, 8'd5, 0);
        do_op(2'd3, 8'd100, 8'd7, 0);
        do_op(2'd3, 8'd3, 8'd9, 0);
        do_op(2'd3, 8'd50, 8'd0, 2);
        do_op(2'd2, 8'd37, 8'd201, 20);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.op_code   = 2'd2;
        bus.a         = 8'd200;
        bus.b         = 8'd3;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_result", 32'(bus.result), 32'd0);
        check("midrst_err", 32'(bus.err), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("midrst_no_rsp", 32'(seen), 32'd0);
        do_op(2'd0, 8'd1, 8'd2, 0);

        // Random operations with short back-pressure.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            rx  = 8'($urandom);
            ry  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            do_op(rop, rx, ry, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
